// File: rtl/autoneg_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : autoneg_scheduler_if
//  Description : Bundles the control, page and burst-handshake signals of the
//                autonegotiation scheduler.
//                slave  - scheduler side (drives burst_start, tx_lcw, status)
//                master - environment side (drives enable, restart, pages,
//                         burst_busy)
//  Signals     : enable, restart, adv_ability[15:0], rx_lcw_valid,
//                rx_lcw[15:0], burst_busy            (environment -> scheduler)
//                burst_start, tx_lcw[15:0], an_state[2:0],
//                partner_ability[15:0], an_complete  (scheduler -> environment)
//  Revision    : 1.0 - initial release
// ============================================================================
interface autoneg_scheduler_if;
   logic        enable;
   logic        restart;
   logic [15:0] adv_ability;
   logic        rx_lcw_valid;
   logic [15:0] rx_lcw;
   logic        burst_busy;
   logic        burst_start;
   logic [15:0] tx_lcw;
   logic [2:0]  an_state;
   logic [15:0] partner_ability;
   logic        an_complete;

   modport slave (
      input  enable, restart, adv_ability, rx_lcw_valid, rx_lcw, burst_busy,
      output burst_start, tx_lcw, an_state, partner_ability, an_complete
   );

   modport master (
      output enable, restart, adv_ability, rx_lcw_valid, rx_lcw, burst_busy,
      input  burst_start, tx_lcw, an_state, partner_ability, an_complete
   );
endinterface
`default_nettype wire

// File: rtl/autoneg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : autoneg_scheduler
//  Description : Base-page autonegotiation arbitration. Schedules FLP bursts
//                every BURST_INTERVAL cycles, detects the partner's ability
//                and acknowledge words, and reports link completion.
//  Ports       : CLK16 - sole clock (rising edge)
//                RST   - synchronous active-high reset
//                an    - autoneg_scheduler_if.slave bundle:
//                        enable, restart, adv_ability, rx_lcw_valid, rx_lcw,
//                        burst_busy in; burst_start, tx_lcw, an_state,
//                        partner_ability, an_complete out
//  Revision    : 1.0 - initial release
// ============================================================================
module autoneg_scheduler #(
   parameter int BURST_INTERVAL  = 256000,
   parameter int MATCH_COUNT     = 3,
   parameter int COMPLETE_BURSTS = 6
) (
   input  wire logic            CLK16,
   input  wire logic            RST,
   autoneg_scheduler_if.slave   an
);

   localparam int c_cnt_w = (BURST_INTERVAL > 1) ? $clog2(BURST_INTERVAL) : 1;
   localparam int c_mat_w = $clog2(MATCH_COUNT + 1);
   localparam int c_bst_w = $clog2(COMPLETE_BURSTS + 1);

   localparam logic [c_cnt_w-1:0] c_term        = c_cnt_w'(BURST_INTERVAL - 1);
   localparam logic [c_mat_w-1:0] c_match_tgt   = c_mat_w'(MATCH_COUNT);
   localparam logic [c_mat_w-1:0] c_match_one   = c_mat_w'(1);
   localparam logic [c_bst_w-1:0] c_bursts_tgt  = c_bst_w'(COMPLETE_BURSTS);
   localparam logic [15:0]        c_ack_mask    = 16'hBFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ABILITY  = 3'd1,
      ST_ACK      = 3'd2,
      ST_COMPLETE = 3'd3,
      ST_LINK     = 3'd4
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_mat_w-1:0]   r_match;
   logic [c_bst_w-1:0]   r_bursts;
   logic [15:0]          r_prev;
   logic [15:0]          r_partner;
   logic [15:0]          r_tx;
   logic                 r_burst_start;
   logic                 r_an_complete;

   logic [15:0]          w_rx_masked;
   logic                 w_active;
   logic                 w_at_term;
   logic                 w_bursts_done;
   logic                 w_fire;
   logic [c_mat_w-1:0]   w_ad_count;
   logic [c_mat_w-1:0]   w_ack_count;
   logic [15:0]          w_tx_word;

   assign w_rx_masked   = an.rx_lcw & c_ack_mask;
   assign w_active      = (r_state == ST_ABILITY) || (r_state == ST_ACK) ||
                          (r_state == ST_COMPLETE);
   assign w_at_term     = (r_cnt == c_term);
   // Once the last completion burst has been issued no further burst may be
   // requested while the FSM is leaving COMPLETE_ACK.
   assign w_bursts_done = (r_state == ST_COMPLETE) && (r_bursts == c_bursts_tgt);
   // A terminal count with the generator busy simply waits: the counter is
   // held at terminal so exactly one burst goes out once busy drops.
   assign w_fire        = w_active && w_at_term && !an.burst_busy && !w_bursts_done;
   assign w_ad_count    = (w_rx_masked == r_prev) ? (r_match + 1'b1) : c_match_one;
   assign w_ack_count   = r_match + 1'b1;
   assign w_tx_word     = {an.adv_ability[15], (r_state != ST_ABILITY),
                           an.adv_ability[13:0]};

   always_ff @(posedge CLK16) begin
      if (RST) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_match       <= '0;
         r_bursts      <= '0;
         r_prev        <= '0;
         r_partner     <= '0;
         r_tx          <= '0;
         r_burst_start <= 1'b0;
         r_an_complete <= 1'b0;
      end else if (!an.enable) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_match       <= '0;
         r_bursts      <= '0;
         r_burst_start <= 1'b0;
         r_an_complete <= 1'b0;
      end else if (an.restart) begin
         // Interval restarts preloaded at terminal so the first burst of the
         // new negotiation goes out as soon as the generator is idle.
         r_state       <= ST_ABILITY;
         r_cnt         <= c_term;
         r_match       <= '0;
         r_bursts      <= '0;
         r_partner     <= '0;
         r_burst_start <= 1'b0;
         r_an_complete <= 1'b0;
      end else begin
         // Burst scheduling uses the current state; any state change decided
         // below takes effect after this cycle.
         r_burst_start <= w_fire;
         if (w_fire) begin
            r_cnt <= '0;
            r_tx  <= w_tx_word;
            if (r_state == ST_COMPLETE) begin
               r_bursts <= r_bursts + 1'b1;
            end
         end else if (w_active && !w_at_term) begin
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_state  <= ST_ABILITY;
               r_cnt    <= c_term;
               r_match  <= '0;
               r_bursts <= '0;
            end

            ST_ABILITY: begin
               if (an.rx_lcw_valid) begin
                  r_prev <= w_rx_masked;
                  if (w_ad_count == c_match_tgt) begin
                     r_partner <= w_rx_masked;
                     r_state   <= ST_ACK;
                     r_match   <= '0;
                  end else begin
                     r_match <= w_ad_count;
                  end
               end
            end

            ST_ACK: begin
               if (an.rx_lcw_valid) begin
                  if (w_rx_masked != r_partner) begin
                     // A different page counts as the first of a new run.
                     r_state <= ST_ABILITY;
                     r_match <= c_match_one;
                     r_prev  <= w_rx_masked;
                  end else if (an.rx_lcw[14]) begin
                     if (w_ack_count == c_match_tgt) begin
                        r_state  <= ST_COMPLETE;
                        r_match  <= '0;
                        r_bursts <= '0;
                     end else begin
                        r_match <= w_ack_count;
                     end
                  end
               end
            end

            ST_COMPLETE: begin
               if (w_bursts_done) begin
                  r_state       <= ST_LINK;
                  r_cnt         <= '0;
                  r_an_complete <= 1'b1;
               end
            end

            ST_LINK: begin
               r_cnt <= '0;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign an.burst_start     = r_burst_start;
   assign an.tx_lcw          = r_tx;
   assign an.an_state        = r_state;
   assign an.partner_ability = r_partner;
   assign an.an_complete     = r_an_complete;

endmodule
`default_nettype wire

// File: tb/tb_autoneg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_autoneg_scheduler
//  Description : Self-checking bench for autoneg_scheduler: a vector table of
//                multi-cycle records, hand sequences for the ACK-mismatch and
//                reset-during-COMPLETE_ACK cases, and a randomized phase
//                checked against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_autoneg_scheduler;
   localparam int BI = 100;
   localparam int MC = 3;
   localparam int CB = 6;

   logic CLK16 = 1'b0;
   logic RST;
   always #5 CLK16 = ~CLK16;

   autoneg_scheduler_if bus ();

   autoneg_scheduler #(
      .BURST_INTERVAL  (BI),
      .MATCH_COUNT     (MC),
      .COMPLETE_BURSTS (CB)
   ) dut (
      .CLK16 (CLK16),
      .RST   (RST),
      .an    (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK16);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      bus.rx_lcw       = w;
      bus.rx_lcw_valid = 1'b1;
      tick();
      bus.rx_lcw_valid = 1'b0;
   endtask

   // ---------------------------------------------------------------- table
   typedef struct {
      int          n;
      bit          rst, en, rs, v;
      logic [15:0] rx;
      bit          busy;
      logic [2:0]  st;
      bit          bs;
      logic [15:0] tx, pa;
      bit          cpl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int n, bit rst, bit en, bit rs, bit v, logic [15:0] rx,
                               bit busy, logic [2:0] st, bit bs, logic [15:0] tx,
                               logic [15:0] pa, bit cpl);
      vec_t r;
      r.n = n; r.rst = rst; r.en = en; r.rs = rs; r.v = v; r.rx = rx; r.busy = busy;
      r.st = st; r.bs = bs; r.tx = tx; r.pa = pa; r.cpl = cpl;
      return r;
   endfunction

   // ---------------------------------------------------------------- model
   int          m_state, m_wait, m_match, m_done;
   logic [15:0] m_prev, m_partner, m_tx;
   bit          m_bs, m_cpl;

   // m_wait counts cycles still to go before a burst is due (0 = due now).
   task automatic model_step(input bit rst, input bit en, input bit rs, input logic [15:0] adv,
                             input bit v, input logic [15:0] rx, input bit busy);
      logic [15:0] w;
      int          s0, done0, n;
      bit          fire;
      w = rx & 16'hBFFF;
      if (rst) begin
         m_state = 0; m_wait = 0; m_match = 0; m_done = 0;
         m_prev = 0; m_partner = 0; m_tx = 0; m_bs = 0; m_cpl = 0;
      end else if (!en) begin
         m_state = 0; m_bs = 0; m_cpl = 0;
      end else if (rs) begin
         m_state = 1; m_match = 0; m_partner = 0; m_wait = 0; m_done = 0; m_bs = 0; m_cpl = 0;
      end else if (m_state == 0) begin
         m_state = 1; m_match = 0; m_done = 0; m_wait = 0; m_bs = 0;
      end else if (m_state == 4) begin
         m_bs = 0;
      end else begin
         s0    = m_state;
         done0 = m_done;
         fire  = (m_wait == 0) && !busy && !(s0 == 3 && done0 == CB);
         m_bs  = fire;
         if (fire) begin
            m_tx   = {adv[15], (s0 != 1), adv[13:0]};
            m_wait = BI - 1;
            if (s0 == 3) m_done++;
         end else if (m_wait > 0) begin
            m_wait--;
         end
         if (s0 == 3) begin
            if (done0 == CB) begin
               m_state = 4; m_cpl = 1;
            end
         end else if (v && s0 == 1) begin
            n = (w == m_prev) ? m_match + 1 : 1;
            m_prev = w;
            if (n == MC) begin
               m_partner = w; m_state = 2; m_match = 0;
            end else m_match = n;
         end else if (v && s0 == 2) begin
            if (w != m_partner) begin
               m_state = 1; m_match = 1; m_prev = w;
            end else if (rx[14]) begin
               n = m_match + 1;
               if (n == MC) begin
                  m_state = 3; m_match = 0; m_done = 0;
               end else m_match = n;
            end
         end
      end
   endtask

   logic [15:0] pool [4] = '{16'h01E1, 16'h41E1, 16'h0021, 16'h4021};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          mid;
      bit          seen;
      bit          r_rst, r_en, r_rs, r_v, r_busy;
      logic [15:0] r_adv, r_rx;

      RST = 1'b0;
      bus.enable = 1'b0; bus.restart = 1'b0; bus.adv_ability = 16'h81E1;
      bus.rx_lcw_valid = 1'b0; bus.rx_lcw = 16'h0; bus.burst_busy = 1'b0;
      #1;

      // n, rst, en, rs, v, rx, busy,   st, bs, tx, pa, cpl
      tbl.push_back(mk(  1, 1, 0, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 97, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h01E1, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h01E1, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h01E1, 0,  2, 0, 16'h81E1, 16'h01E1, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h41E1, 0,  2, 0, 16'h81E1, 16'h01E1, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h41E1, 0,  2, 0, 16'h81E1, 16'h01E1, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 1, 16'h41E1, 0,  3, 0, 16'h81E1, 16'h01E1, 0));
      tbl.push_back(mk( 93, 0, 1, 0, 0, 16'h0000, 0,  3, 0, 16'h81E1, 16'h01E1, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  3, 1, 16'hC1E1, 16'h01E1, 0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(100, 0, 1, 0, 0, 16'h0000, 0,  3, 1, 16'hC1E1, 16'h01E1, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  4, 0, 16'hC1E1, 16'h01E1, 1));
      tbl.push_back(mk(150, 0, 1, 0, 0, 16'h0000, 0,  4, 0, 16'hC1E1, 16'h01E1, 1));
      tbl.push_back(mk(  1, 0, 1, 1, 0, 16'h0000, 0,  1, 0, 16'hC1E1, 16'h0000, 0));
      tbl.push_back(mk(  5, 0, 1, 0, 0, 16'h0000, 1,  1, 0, 16'hC1E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 0, 0, 0, 16'h0000, 0,  0, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 1,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 30, 0, 1, 0, 0, 16'h0000, 1,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 98, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 99, 0, 1, 0, 0, 16'h0000, 1,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 30, 0, 1, 0, 0, 16'h0000, 1,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk( 98, 0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h81E1, 16'h0000, 0));
      tbl.push_back(mk(  1, 0, 1, 0, 0, 16'h0000, 0,  1, 1, 16'h81E1, 16'h0000, 0));

      foreach (tbl[i]) begin
         RST = tbl[i].rst; bus.enable = tbl[i].en; bus.restart = tbl[i].rs;
         bus.rx_lcw_valid = tbl[i].v; bus.rx_lcw = tbl[i].rx; bus.burst_busy = tbl[i].busy;
         mid = 0;
         for (int k = 0; k < tbl[i].n; k++) begin
            if (k == 1) begin
               bus.rx_lcw_valid = 1'b0;
               bus.restart      = 1'b0;
            end
            tick();
            if (k < tbl[i].n - 1 && bus.burst_start) mid++;
         end
         check($sformatf("vec%0d.an_state", i), 64'(bus.an_state), 64'(tbl[i].st));
         check($sformatf("vec%0d.burst_start", i), 64'(bus.burst_start), 64'(tbl[i].bs));
         check($sformatf("vec%0d.tx_lcw", i), 64'(bus.tx_lcw), 64'(tbl[i].tx));
         check($sformatf("vec%0d.partner_ability", i), 64'(bus.partner_ability), 64'(tbl[i].pa));
         check($sformatf("vec%0d.an_complete", i), 64'(bus.an_complete), 64'(tbl[i].cpl));
         if (tbl[i].n > 1)
            check($sformatf("vec%0d.mid_bursts", i), 64'(mid), 64'd0);
      end
      bus.restart = 1'b0; bus.rx_lcw_valid = 1'b0; bus.burst_busy = 1'b0;

      // ------------------------------------------ ACK_DETECT page mismatch
      RST = 1'b1; tick(); RST = 1'b0;
      bus.enable = 1'b1; tick();
      repeat (3) send(16'h01E1);
      check("ackmis.reach_ack", 64'(bus.an_state), 64'd2);
      send(16'h0021);
      check("ackmis.back_to_ability", 64'(bus.an_state), 64'd1);
      send(16'h0021);
      check("ackmis.second_word", 64'(bus.an_state), 64'd1);
      send(16'h0021);
      check("ackmis.reack_state", 64'(bus.an_state), 64'd2);
      check("ackmis.partner", 64'(bus.partner_ability), 64'h0021);

      // ------------------------------------------ reset during COMPLETE_ACK
      repeat (3) send(16'h4021);
      check("rstcack.state", 64'(bus.an_state), 64'd3);
      seen = 1'b0;
      for (int k = 0; k < 2 * BI && !seen; k++) begin
         tick();
         if (bus.burst_start) seen = 1'b1;
      end
      check("rstcack.burst_seen", 64'(seen), 64'd1);
      RST = 1'b1; tick();
      check("rstcack.state0", 64'(bus.an_state), 64'd0);
      check("rstcack.bs0", 64'(bus.burst_start), 64'd0);
      check("rstcack.tx0", 64'(bus.tx_lcw), 64'd0);
      check("rstcack.pa0", 64'(bus.partner_ability), 64'd0);
      check("rstcack.cpl0", 64'(bus.an_complete), 64'd0);
      RST = 1'b0; tick();
      check("rstcack.reenter", 64'(bus.an_state), 64'd1);
      tick();
      check("rstcack.first_burst", 64'(bus.burst_start), 64'd1);
      check("rstcack.tx_ack0", 64'(bus.tx_lcw), 64'h81E1);

      // ------------------------------------------ randomized vs model
      r_adv = 16'h81E1;
      for (int c = 0; c < 6000; c++) begin
         r_rst  = (c == 0) || ($urandom_range(0, 2999) == 0);
         r_en   = ($urandom_range(0, 1499) != 0);
         r_rs   = ($urandom_range(0, 699) == 0);
         r_v    = ($urandom_range(0, 3) == 0);
         r_rx   = pool[$urandom_range(0, 3)];
         r_busy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) r_adv = 16'($urandom);
         RST = r_rst; bus.enable = r_en; bus.restart = r_rs; bus.adv_ability = r_adv;
         bus.rx_lcw_valid = r_v; bus.rx_lcw = r_rx; bus.burst_busy = r_busy;
         model_step(r_rst, r_en, r_rs, r_adv, r_v, r_rx, r_busy);
         tick();
         check($sformatf("rand%0d.outputs", c),
               {27'd0, bus.an_state, bus.burst_start, bus.tx_lcw, bus.partner_ability, bus.an_complete},
               {27'd0, 3'(m_state), m_bs, m_tx, m_partner, m_cpl});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
